// File: rtl/hc_pkg.sv
// Shared constants and types for the 16-bit core's register file and hazard scoreboard.
package hc_pkg;
    localparam int unsigned NREG = 32;
    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 5;

    localparam int unsigned NZCV_N = 3;
    localparam int unsigned NZCV_Z = 2;
    localparam int unsigned NZCV_C = 1;
    localparam int unsigned NZCV_V = 0;

    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [3:0]    nzcv_t;
endpackage

// File: rtl/hc_scoreboard.sv
// Busy-bit scoreboard: RAW/WAW hazard detection against in-flight destinations,
// reserve/clear arbitration and a registered count of busy registers.
module hc_scoreboard #(
    parameter int unsigned NREG = hc_pkg::NREG,
    parameter int unsigned AW   = hc_pkg::AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_idx,
    input  logic            iss_valid,
    input  logic [AW-1:0]   src_a,
    input  logic [AW-1:0]   src_b,
    input  logic            dst_en,
    input  logic [AW-1:0]   dst,
    output logic            stall,
    output logic [NREG-1:0] busy,
    output logic [AW:0]     pending_cnt
);
    import hc_pkg::*;

    localparam int unsigned CW = AW + 1;

    logic [NREG-1:0] busy_q, busy_d, clr_vec, set_vec;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            hz_a, hz_b, hz_d;

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        if (clr_en)
            clr_vec[clr_idx] = 1'b1;
        // A write-back landing this cycle releases the hazard immediately.
        hz_a  = busy_q[src_a] && !clr_vec[src_a];
        hz_b  = busy_q[src_b] && !clr_vec[src_b];
        hz_d  = dst_en && busy_q[dst] && !clr_vec[dst];
        stall = iss_valid && (hz_a || hz_b || hz_d);
        if (iss_valid && !stall && dst_en)
            set_vec[dst] = 1'b1;
        set_vec[0] = 1'b0;
        // Set applied after clear: a same-cycle reserve of the index wins.
        busy_d = (busy_q & ~clr_vec) | set_vec;
        cnt_d  = '0;
        for (int unsigned i = 0; i < NREG; i++)
            cnt_d = cnt_d + CW'(busy_d[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy        = busy_q;
    assign pending_cnt = cnt_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with registered, write-bypassed operand reads,
// NZCV flags, and hazard-based issue stalling via hc_scoreboard.
module regfile_scoreboard #(
    parameter int unsigned NREG = hc_pkg::NREG,
    parameter int unsigned DW   = hc_pkg::DW,
    parameter int unsigned AW   = hc_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_w_en,
    input  logic [AW-1:0] wb_w_idx,
    input  logic [DW-1:0] wb_w_data,
    input  logic          wb_nzcv_en,
    input  logic [3:0]    wb_nzcv,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_src_a,
    input  logic [AW-1:0] iss_src_b,
    input  logic          iss_dst_en,
    input  logic [AW-1:0] iss_dst,
    output logic          iss_stall,
    output logic          op_valid,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic [3:0]    op_nzcv,
    output logic [AW:0]   pending_cnt,
    output logic          wb_err
);
    import hc_pkg::*;

    logic [DW-1:0]   regs [NREG];
    nzcv_t           nzcv;
    logic [NREG-1:0] busy;
    logic [DW-1:0]   rd_a, rd_b;
    nzcv_t           rd_nzcv;
    logic            accept, wb_wr;

    hc_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .clr_en      (wb_w_en),
        .clr_idx     (wb_w_idx),
        .iss_valid   (iss_valid),
        .src_a       (iss_src_a),
        .src_b       (iss_src_b),
        .dst_en      (iss_dst_en),
        .dst         (iss_dst),
        .stall       (iss_stall),
        .busy        (busy),
        .pending_cnt (pending_cnt)
    );

    always_comb begin
        accept  = iss_valid && !iss_stall;
        wb_wr   = wb_w_en && (wb_w_idx != '0);
        rd_a    = regs[iss_src_a];
        rd_b    = regs[iss_src_b];
        rd_nzcv = wb_nzcv_en ? wb_nzcv : nzcv;
        if (wb_wr && wb_w_idx == iss_src_a)
            rd_a = wb_w_data;
        if (wb_wr && wb_w_idx == iss_src_b)
            rd_b = wb_w_data;
        if (iss_src_a == '0)
            rd_a = '0;
        if (iss_src_b == '0)
            rd_b = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++)
                regs[i] <= '0;
            nzcv     <= '0;
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_nzcv  <= '0;
            wb_err   <= 1'b0;
        end else begin
            if (wb_wr) begin
                regs[wb_w_idx] <= wb_w_data;
                if (!busy[wb_w_idx])
                    wb_err <= 1'b1;
            end
            if (wb_nzcv_en)
                nzcv <= wb_nzcv;
            op_valid <= accept;
            if (accept) begin
                op_a    <= rd_a;
                op_b    <= rd_b;
                op_nzcv <= rd_nzcv;
            end
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus randomized bench for regfile_scoreboard against an array-based reference model.
module tb_regfile_scoreboard;
    import hc_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_w_en;
    logic [AW-1:0] wb_w_idx;
    logic [DW-1:0] wb_w_data;
    logic          wb_nzcv_en;
    logic [3:0]    wb_nzcv;
    logic          iss_valid;
    logic [AW-1:0] iss_src_a, iss_src_b, iss_dst;
    logic          iss_dst_en;
    logic          iss_stall, op_valid, wb_err;
    logic [DW-1:0] op_a, op_b;
    logic [3:0]    op_nzcv;
    logic [AW:0]   pending_cnt;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .NREG (NREG),
        .DW   (DW),
        .AW   (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_w_en     (wb_w_en),
        .wb_w_idx    (wb_w_idx),
        .wb_w_data   (wb_w_data),
        .wb_nzcv_en  (wb_nzcv_en),
        .wb_nzcv     (wb_nzcv),
        .iss_valid   (iss_valid),
        .iss_src_a   (iss_src_a),
        .iss_src_b   (iss_src_b),
        .iss_dst_en  (iss_dst_en),
        .iss_dst     (iss_dst),
        .iss_stall   (iss_stall),
        .op_valid    (op_valid),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_nzcv     (op_nzcv),
        .pending_cnt (pending_cnt),
        .wb_err      (wb_err)
    );

    // Reference model state
    logic [15:0] m_regs [32];
    bit          m_busy [32];
    logic [3:0]  m_nzcv;
    bit          m_err;
    bit          e_valid;
    logic [15:0] e_a, e_b;
    logic [3:0]  e_nzcv;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int busy_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += m_busy[i] ? 1 : 0;
        return n;
    endfunction

    function automatic bit hazard(input int idx, input bit we, input int wi);
        return m_busy[idx] && !(we && wi == idx);
    endfunction

    function automatic logic [15:0] model_read(input int idx, input bit we, input int wi,
                                               input logic [15:0] wd);
        if (idx == 0) return 16'h0;
        if (we && wi == idx) return wd;
        return m_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_nzcv = '0; m_err = 1'b0;
        e_valid = 1'b0; e_a = '0; e_b = '0; e_nzcv = '0;
    endtask

    // One clock cycle: drive, check stall before the edge, advance model, check registered outputs.
    task automatic step(input bit rst, input bit we, input int wi, input logic [15:0] wd,
                        input bit ne, input logic [3:0] nz, input bit v, input int a,
                        input int b, input bit de, input int d);
        bit exp_stall, acc;
        reset = rst; wb_w_en = we; wb_w_idx = AW'(wi); wb_w_data = wd;
        wb_nzcv_en = ne; wb_nzcv = nz; iss_valid = v;
        iss_src_a = AW'(a); iss_src_b = AW'(b); iss_dst_en = de; iss_dst = AW'(d);
        #1;
        exp_stall = v && (hazard(a, we, wi) || hazard(b, we, wi) || (de && hazard(d, we, wi)));
        chk("iss_stall", 32'(iss_stall), 32'(exp_stall));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            acc = v && !exp_stall;
            e_valid = acc;
            if (acc) begin
                e_a    = model_read(a, we, wi, wd);
                e_b    = model_read(b, we, wi, wd);
                e_nzcv = ne ? nz : m_nzcv;
            end
            if (we && wi != 0) begin
                if (!m_busy[wi]) m_err = 1'b1;
                m_regs[wi] = wd;
                m_busy[wi] = 1'b0;
            end
            if (ne) m_nzcv = nz;
            if (acc && de && d != 0) m_busy[d] = 1'b1;
        end
        #1;
        chk("op_valid", 32'(op_valid), 32'(e_valid));
        chk("op_a", 32'(op_a), 32'(e_a));
        chk("op_b", 32'(op_b), 32'(e_b));
        chk("op_nzcv", 32'(op_nzcv), 32'(e_nzcv));
        chk("pending_cnt", 32'(pending_cnt), 32'(busy_count()));
        chk("wb_err", 32'(wb_err), 32'(m_err));
    endtask

    task automatic idle();
        step(0, 0, 0, 16'h0, 0, 4'h0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue(input int a, input int b, input bit de, input int d);
        step(0, 0, 0, 16'h0, 0, 4'h0, 1, a, b, de, d);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 16'h0, 0, 4'h0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; wb_w_en = 0; wb_w_idx = '0; wb_w_data = '0; wb_nzcv_en = 0;
        wb_nzcv = '0; iss_valid = 0; iss_src_a = '0; iss_src_b = '0; iss_dst_en = 0; iss_dst = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;

        // Reset state, then read r3/r0
        do_reset();
        chk("reset_pending", 32'(pending_cnt), 32'd0);
        issue(3, 0, 0, 0);
        chk("t1_valid", 32'(op_valid), 32'd1);
        chk("t1_a", 32'(op_a), 32'd0);

        // Flag bypass on accept
        step(0, 0, 0, 16'h0, 1, 4'b1010, 1, 0, 0, 0, 0);
        chk("nzcv_bypass", 32'(op_nzcv), 32'hA);

        // RAW stall on r5 released by same-cycle write-back
        issue(0, 0, 1, 5);
        chk("t2_pending1", 32'(pending_cnt), 32'd1);
        issue(5, 0, 0, 0);
        chk("t2_stalled_valid", 32'(op_valid), 32'd0);
        issue(5, 0, 0, 0);
        step(0, 1, 5, 16'h1234, 0, 4'h0, 1, 5, 0, 0, 0);
        chk("t2_op_a", 32'(op_a), 32'h1234);
        chk("t2_pending0", 32'(pending_cnt), 32'd0);

        // Write-to-read bypass on non-busy r7, then stored value
        step(0, 1, 7, 16'hBEEF, 0, 4'h0, 1, 0, 7, 0, 0);
        chk("t3_bypass_b", 32'(op_b), 32'hBEEF);
        idle();
        issue(7, 7, 0, 0);
        chk("t3_stored", 32'(op_a), 32'hBEEF);

        // Clear and re-reserve r9 in the same cycle
        do_reset();
        issue(0, 0, 1, 9);
        idle();
        step(0, 1, 9, 16'h5A5A, 0, 4'h0, 1, 0, 0, 1, 9);
        chk("t4_accept", 32'(op_valid), 32'd1);
        chk("t4_pending", 32'(pending_cnt), 32'd1);
        issue(9, 0, 0, 0);
        chk("t4_still_busy", 32'(op_valid), 32'd0);

        // r0 writes ignored; wb to non-busy r4 sets sticky error
        do_reset();
        step(0, 1, 0, 16'hFFFF, 0, 4'h0, 0, 0, 0, 0, 0);
        chk("t5_no_err_r0", 32'(wb_err), 32'd0);
        issue(0, 0, 0, 0);
        chk("t5_r0", 32'(op_a), 32'd0);
        step(0, 1, 4, 16'h0C0D, 0, 4'h0, 0, 0, 0, 0, 0);
        chk("t5_err", 32'(wb_err), 32'd1);
        issue(4, 0, 0, 0);
        chk("t5_r4", 32'(op_a), 32'h0C0D);
        idle();
        chk("t5_sticky", 32'(wb_err), 32'd1);

        // Reserve r1..r3 then reset
        issue(0, 0, 1, 1);
        issue(0, 0, 1, 2);
        issue(0, 0, 1, 3);
        chk("t6_pending3", 32'(pending_cnt), 32'd3);
        do_reset();
        chk("t6_pending0", 32'(pending_cnt), 32'd0);
        chk("t6_err0", 32'(wb_err), 32'd0);
        issue(1, 2, 1, 3);
        chk("t6_no_stall", 32'(op_valid), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 1) == 1), int'($urandom_range(0, 15)), 16'($urandom),
                 ($urandom_range(0, 3) == 0), 4'($urandom),
                 ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1),
                 int'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
